// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: state encodings and shared constants for the user-area Wishbone arbiter
package wb_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } state_t;
    localparam int CNT_W = 16;
    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/wb_ack_timeout.sv
// wb_ack_timeout: wait counter with clear/enable that flags the last allowed wait cycle
module wb_ack_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
    // tc only fires on a counting cycle, so a coincident ack (en=0) always wins
    assign tc = (TIMEOUT_CYCLES != 0) && en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wb_user_arbiter.sv
// wb_user_arbiter: round-robin two-master Wishbone arbiter with slave-ack timeout abort
module wb_user_arbiter
    import wb_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic        timeout_o,
    output logic        timeout_src_o,
    input  logic        timeout_clr_i
);
    state_t state_q, state_d;
    logic   last_q, last_d, tout_q, tout_d, src_q, src_d;
    logic   req0, req1, g0, g1, ab, tc;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign g0   = state_q == GRANT0;
    assign g1   = state_q == GRANT1;
    assign ab   = state_q == ABORT;

    wb_ack_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (~(g0 | g1) | s_ack_i),
        .en  (s_stb_o & ~s_ack_i),
        .tc  (tc)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            tout_q  <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            tout_q  <= tout_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: state_d = (req0 & req1) ? (last_q ? GRANT0 : GRANT1) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
            GRANT0, GRANT1: begin
                if (!(g1 ? m1_cyc_i : m0_cyc_i)) begin
                    state_d = IDLE;
                    last_d  = g1;
                end else if (tc) state_d = ABORT;
            end
            default: begin
                if (src_q ? m1_cyc_i : m0_cyc_i) state_d = src_q ? GRANT1 : GRANT0;
                else begin
                    state_d = IDLE;
                    last_d  = src_q;
                end
            end
        endcase
        // src is captured on entry so it names the aborted master during ABORT itself
        src_d  = (state_d == ABORT && !ab) ? g1 : src_q;
        tout_d = (state_d == ABORT || ab) ? 1'b1 : timeout_clr_i ? 1'b0 : tout_q;
    end

    always_comb begin
        s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
        s_stb_o  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
        s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
        s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'h0;
        s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : 32'h0;
        s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : 32'h0;
        m0_ack_o = (g0 & s_ack_i) | (ab & ~src_q);
        m1_ack_o = (g1 & s_ack_i) | (ab & src_q);
        m0_dat_o = g0 ? s_dat_i : (ab & ~src_q) ? TIMEOUT_DATA : 32'h0;
        m1_dat_o = g1 ? s_dat_i : (ab & src_q) ? TIMEOUT_DATA : 32'h0;
    end

    assign timeout_o     = tout_q;
    assign timeout_src_o = src_q;
endmodule
